dualport_ram_arbiter: RTL

Two-requester arbiter and sequencer in front of the `dualport_ram` block. It shares the RAM's single write port and single read port between requesters A and B. Contention on each port is resolved by its own round-robin pointer. Read data returns to the issuing requester over a valid/ready request channel and a fixed-latency response channel.

---
 rtl/dualport_ram_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dualport_ram_arbiter.sv
// Two-requester arbiter in front of dualport_ram: round-robin per RAM port, fixed 2-cycle read response.
// Optional macro DPRAM_ARB_RAW_BYPASS_EN forwards same-cycle write data to a colliding read.
module dualport_ram_arbiter #(
   parameter int MEM_WIDTH  = 16,
   parameter int ADDER_SIZE = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req_valid,
   input  logic                  a_req_we,
   input  logic [ADDER_SIZE-1:0] a_req_addr,
   input  logic [MEM_WIDTH-1:0]  a_req_wdata,
   output logic                  a_req_ready,
   output logic                  a_rsp_valid,
   output logic [MEM_WIDTH-1:0]  a_rsp_rdata,
   input  logic                  b_req_valid,
   input  logic                  b_req_we,
   input  logic [ADDER_SIZE-1:0] b_req_addr,
   input  logic [MEM_WIDTH-1:0]  b_req_wdata,
   output logic                  b_req_ready,
   output logic                  b_rsp_valid,
   output logic [MEM_WIDTH-1:0]  b_rsp_rdata,
   output logic [MEM_WIDTH-1:0]  ram_din,
   output logic [ADDER_SIZE-1:0] ram_addr_wr,
   output logic [ADDER_SIZE-1:0] ram_addr_rd,
   output logic                  ram_wr_en,
   output logic                  ram_rd_en,
   output logic                  ram_blk_select,
   input  logic [MEM_WIDTH-1:0]  ram_dout
);

   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

   req_id_t wr_ptr;
   req_id_t rd_ptr;
   req_id_t s1_owner;
   logic    s1_valid;
   logic    active_q;

   logic a_wr, a_rd, b_wr, b_rd;
   logic a_wr_gnt, a_rd_gnt, b_wr_gnt, b_rd_gnt;
   logic [MEM_WIDTH-1:0] rsp_data;

   // active_q holds grants off until the first edge after reset release
   assign a_wr = active_q & a_req_valid &  a_req_we;
   assign a_rd = active_q & a_req_valid & ~a_req_we;
   assign b_wr = active_q & b_req_valid &  b_req_we;
   assign b_rd = active_q & b_req_valid & ~b_req_we;

   assign a_wr_gnt = a_wr & (~b_wr | (wr_ptr == REQ_A));
   assign b_wr_gnt = b_wr & (~a_wr | (wr_ptr == REQ_B));
   assign a_rd_gnt = a_rd & (~b_rd | (rd_ptr == REQ_A));
   assign b_rd_gnt = b_rd & (~a_rd | (rd_ptr == REQ_B));

   assign a_req_ready = a_wr_gnt | a_rd_gnt;
   assign b_req_ready = b_wr_gnt | b_rd_gnt;

   always_comb begin
      ram_wr_en   = a_wr_gnt | b_wr_gnt;
      ram_rd_en   = a_rd_gnt | b_rd_gnt;
      ram_addr_wr = '0;
      ram_din     = '0;
      ram_addr_rd = '0;
      if (a_wr_gnt) begin
         ram_addr_wr = a_req_addr;
         ram_din     = a_req_wdata;
      end else if (b_wr_gnt) begin
         ram_addr_wr = b_req_addr;
         ram_din     = b_req_wdata;
      end
      if (a_rd_gnt) begin
         ram_addr_rd = a_req_addr;
      end else if (b_rd_gnt) begin
         ram_addr_rd = b_req_addr;
      end
   end

   assign ram_blk_select = ram_wr_en | ram_rd_en;

`ifdef DPRAM_ARB_RAW_BYPASS_EN
   logic                 s1_bypass;
   logic [MEM_WIDTH-1:0] s1_wdata;

   // A same-address read/write pair returns the new data, captured beside stage 1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_bypass <= 1'b0;
         s1_wdata  <= '0;
      end else begin
         s1_bypass <= ram_rd_en & ram_wr_en & (ram_addr_rd == ram_addr_wr);
         s1_wdata  <= ram_din;
      end
   end

   assign rsp_data = s1_bypass ? s1_wdata : ram_dout;
`else
   assign rsp_data = ram_dout;
`endif

   // Pointers flip only on contended grants; stage 1 marks the cycle ram_dout is valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q    <= 1'b0;
         wr_ptr      <= REQ_A;
         rd_ptr      <= REQ_A;
         s1_valid    <= 1'b0;
         s1_owner    <= REQ_A;
         a_rsp_valid <= 1'b0;
         b_rsp_valid <= 1'b0;
         a_rsp_rdata <= '0;
         b_rsp_rdata <= '0;
      end else begin
         active_q <= 1'b1;
         if (a_wr && b_wr) begin
            wr_ptr <= (wr_ptr == REQ_A) ? REQ_B : REQ_A;
         end
         if (a_rd && b_rd) begin
            rd_ptr <= (rd_ptr == REQ_A) ? REQ_B : REQ_A;
         end
         s1_valid    <= ram_rd_en;
         s1_owner    <= b_rd_gnt ? REQ_B : REQ_A;
         a_rsp_valid <= s1_valid && (s1_owner == REQ_A);
         b_rsp_valid <= s1_valid && (s1_owner == REQ_B);
         if (s1_valid && (s1_owner == REQ_A)) begin
            a_rsp_rdata <= rsp_data;
         end
         if (s1_valid && (s1_owner == REQ_B)) begin
            b_rsp_rdata <= rsp_data;
         end
      end
   end

endmodule
